// File: rtl/gt_result_packer_pkg.sv
// Shared defaults and constant helpers for the gt comparator result packer.
package gt_result_packer_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_COUNT_W = 6;

  // Smallest r with 2**r >= v; usable in constant expressions.
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gt_result_packer.sv
// Packs the 1-bit gt result stream LSB-first into WIDTH-bit words on a
// valid/ready port; flush closes out a partial word.
module gt_result_packer
  import gt_result_packer_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_z,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] out_count
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("gt_result_packer: WIDTH must be in 2..64");
  end
  if (COUNT_W < clog2_u(WIDTH + 1)) begin : g_bad_count_w
    $error("gt_result_packer: COUNT_W too narrow to hold WIDTH");
  end

  logic [WIDTH-1:0]   r_acc;
  logic [COUNT_W-1:0] r_acc_cnt;
  logic               r_flush_pend;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [COUNT_W-1:0] r_out_count;

  logic               w_full;
  logic               w_slot_free;
  logic               w_xfer;
  logic               w_accept;
  logic [COUNT_W-1:0] w_pos;
  logic [WIDTH-1:0]   w_acc_base;
  logic [WIDTH-1:0]   w_acc_next;
  logic [COUNT_W-1:0] w_cnt_next;
  logic               w_flush_pend_next;

  // Handshake decode; a draining word frees the accumulator for a bit in the same cycle.
  always_comb begin
    w_full      = (r_acc_cnt == COUNT_W'(WIDTH));
    w_slot_free = !r_out_valid || out_ready;
    w_xfer      = w_slot_free && (w_full || (r_flush_pend && (r_acc_cnt != '0)));
    in_ready    = w_xfer || (!w_full && !r_flush_pend);
    w_accept    = in_valid && in_ready;
  end

  // Next accumulator state: on xfer the incoming bit becomes bit 0 of the next word.
  always_comb begin
    w_pos      = w_xfer ? '0 : r_acc_cnt;
    w_acc_base = w_xfer ? '0 : r_acc;
    w_cnt_next = w_pos + COUNT_W'(w_accept);
    w_acc_next = w_acc_base;
    if (w_accept) begin
      w_acc_next = w_acc_base | (WIDTH'(in_z) << w_pos);
    end
    w_flush_pend_next = (r_flush_pend && !w_xfer) || (flush && (w_cnt_next != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_acc_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_acc        <= w_acc_next;
      r_acc_cnt    <= w_cnt_next;
      r_flush_pend <= w_flush_pend_next;
    end
  end

  // Output register: held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_acc;
      r_out_count <= r_acc_cnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_gt_result_packer.sv
// Directed self-checking bench for gt_result_packer (WIDTH=32, COUNT_W=6).
module tb_gt_result_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_z;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_count;

  int errors;
  int checks;

  gt_result_packer #(.WIDTH(32), .COUNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_z      (in_z),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    checks++;
    if (out_count !== 6'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_full_word();
    logic dropped;
    dropped = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_z = (i % 2 == 0);
      #1;
      if (in_ready !== 1'b1) dropped = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL full_in_ready_drop: got %b expected 0", dropped); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", out_valid); end
    checks++;
    if (out_data !== 32'h55555555) begin errors++; $display("FAIL full_data: got %h expected 55555555", out_data); end
    checks++;
    if (out_count !== 6'd32) begin errors++; $display("FAIL full_count: got %0d expected 32", out_count); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_partial_flush();
    logic [4:0] bits;
    bits = 5'b01011;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_z = bits[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b expected 1", out_valid); end
    checks++;
    if (out_data !== 32'h0000000B) begin errors++; $display("FAIL flush_data: got %h expected 0000000b", out_data); end
    checks++;
    if (out_count !== 6'd5) begin errors++; $display("FAIL flush_count: got %0d expected 5", out_count); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic dropped;
    dropped = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_z = (i < 32) ? (i % 4 == 0) : 1'b1;
      #1;
      if (in_ready !== 1'b1) dropped = 1'b1;
      if (i == 33) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_w1_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_data !== 32'h11111111) begin errors++; $display("FAIL b2b_w1_data: got %h expected 11111111", out_data); end
      end
      if (i == 34) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_w1_consumed: got %b expected 0", out_valid); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_drop: got %b expected 0", dropped); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF || out_count !== 6'd32) begin
      errors++;
      $display("FAIL b2b_w2: got valid=%b data=%h count=%0d expected valid=1 data=ffffffff count=32",
               out_valid, out_data, out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int accepted;
    int cyc;
    logic stalled;
    accepted = 0;
    cyc = 0;
    stalled = 1'b0;
    out_ready = 1'b0;
    while (!stalled && cyc < 200) begin
      in_valid = 1'b1;
      in_z = 1'b1;
      #1;
      if (in_ready === 1'b1) begin
        accepted++;
        @(negedge clk);
      end else begin
        stalled = 1'b1;
      end
      cyc++;
    end
    checks++;
    if (accepted != 64 || !stalled) begin
      errors++;
      $display("FAIL bp_accepted_before_stall: got %0d (stalled=%b) expected 64 (stalled=1)", accepted, stalled);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF || out_count !== 6'd32) begin
      errors++;
      $display("FAIL bp_w1_held: got valid=%b data=%h count=%0d expected valid=1 data=ffffffff count=32",
               out_valid, out_data, out_count);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL bp_hold: got in_ready=%b valid=%b data=%h expected in_ready=0 valid=1 data=ffffffff",
               in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_same_cycle: got %b expected 1", in_ready); end
    if (in_ready === 1'b1) accepted++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 6'd32 || out_data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL bp_w2: got valid=%b data=%h count=%0d expected valid=1 data=ffffffff count=32",
               out_valid, out_data, out_count);
    end
    cyc = 0;
    while (accepted < 80 && cyc < 100) begin
      in_valid = 1'b1;
      #1;
      if (in_ready === 1'b1) accepted++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted != 80) begin errors++; $display("FAIL bp_total_accepted: got %0d expected 80", accepted); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000FFFF || out_count !== 6'd16) begin
      errors++;
      $display("FAIL bp_remainder: got valid=%b data=%h count=%0d expected valid=1 data=0000ffff count=16",
               out_valid, out_data, out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_empty_flush();
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_flush_a: got %b expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_flush_b: got %b expected 0", out_valid); end
    in_valid = 1'b1;
    in_z = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL same_flush_early: got %b expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000001 || out_count !== 6'd1) begin
      errors++;
      $display("FAIL same_flush_word: got valid=%b data=%h count=%0d expected valid=1 data=00000001 count=1",
               out_valid, out_data, out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_z = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 6'd10 || out_data !== 32'h000003FF) begin
      errors++;
      $display("FAIL rst_pre_word: got valid=%b data=%h count=%0d expected valid=1 data=000003ff count=10",
               out_valid, out_data, out_count);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_z = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 6'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: got valid=%b data=%h count=%0d in_ready=%b expected valid=0 data=00000000 count=0 in_ready=1",
               out_valid, out_data, out_count, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_z = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0 || out_count !== 6'd32) begin
      errors++;
      $display("FAIL rst_post_word: got valid=%b data=%h count=%0d expected valid=1 data=00000000 count=32",
               out_valid, out_data, out_count);
    end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_z = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_full_word();
    test_partial_flush();
    test_back_to_back();
    test_backpressure();
    test_empty_flush();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gt_result_packer.md
# gt_result_packer

Collects the 1-bit result stream produced by the `gt` comparator and packs it into WIDTH-bit words for a word-wide consumer, such as a result FIFO or a file-dump port. Each word goes out on a valid/ready handshake. Results are packed LSB-first, so result k of a word lands in bit k. A flush pulse closes out a partial word. Backpressure on the word side propagates to the bit side through `in_ready`.

## Interface
- WIDTH, 32, bits per packed word (2..64)
- COUNT_W, 6, width of `out_count`; must satisfy 2**COUNT_W > WIDTH
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  `in_z` holds a result this cycle
- in_z  input  1  comparator result bit
- in_ready  output  1  packer accepts `in_z` this cycle
- flush  input  1  single-cycle request to emit the current partial word
- out_valid  output  1  `out_data`/`out_count` hold a word
- out_ready  input  1  consumer takes the word this cycle
- out_data  output  WIDTH  packed results, bit 0 is the oldest; unused bits 0
- out_count  output  COUNT_W  number of valid bits in `out_data` (1..WIDTH)

## Operation
- **State:**
  - accumulator `acc[WIDTH-1:0]`
  - fill count `acc_cnt` (0..WIDTH)
  - sticky `flush_pend`
  - one output register (`out_data`, `out_count`, `out_valid`)
- **Modes, derived from state:**
  - ACCUM: `acc_cnt` < WIDTH and not `flush_pend`
  - FULL: `acc_cnt` == WIDTH
  - FLUSHING: `flush_pend` set
- **Slot free:** `slot_free = !out_valid || out_ready`.
- **Transfer:** `xfer = slot_free && (acc_cnt == WIDTH || (flush_pend && acc_cnt != 0))`.
  - On xfer: the output register loads `acc` and `acc_cnt`, `out_valid` goes to 1, and `acc` clears.
  - `acc_cnt` becomes 0, or 1 if a bit is accepted in the same cycle.
  - `flush_pend` clears.
- **Input ready:** `in_ready = xfer || (acc_cnt < WIDTH && !flush_pend)`.
- **Bit accepted** (`in_valid && in_ready`):
  - Written to `acc[acc_cnt]`, or to `acc[0]` when xfer is active.
  - `acc_cnt` increments.
- **Flush:**
  - `flush` sets `flush_pend` when `acc_cnt != 0` or a bit is accepted in the same cycle. That bit is included in the flushed word.
  - Flush with `acc_cnt == 0` and no bit accepted is ignored; no zero-length word is ever emitted.
  - Flush while FULL is redundant; the full word goes out normally.
- **Output handshake:**
  - `out_valid && out_ready` without a new xfer clears `out_valid`.
  - With `out_valid` high and `out_ready` low, `out_data`/`out_count` are held stable.
- **Reset** (any time, including mid-word):
  - `acc`, `acc_cnt`, `flush_pend` go to 0.
  - `out_valid`, `out_data`, `out_count` go to 0.
  - The partial word is discarded.
  - `in_ready` is 1 immediately after reset release.

## Timing
- Bit in to word out: the WIDTH-th bit accepted at edge N sets `acc_cnt` = WIDTH. xfer occurs at edge N+1, so `out_valid` rises after N+1, provided the slot is free.
- Sustained throughput: one bit per cycle. While the consumer keeps `out_ready` high, no bubble is inserted at word boundaries.
- Flush latency: flush at edge N gives `out_valid` after edge N+1, provided the slot is free.
- Backpressure:
  - With the slot occupied and `out_ready` low, the packer accepts up to WIDTH further bits.
  - `in_ready` then stays 0 until `out_ready` rises.
  - It returns to 1 in the same cycle that `out_ready` rises.
- All outputs except `in_ready` are registered. `in_ready` is combinational from state and `out_ready`.

## Structure
- Shared package or include holds:
  - default WIDTH/COUNT_W
  - the `clog2`-style constant helper used to check COUNT_W
- Single module; no sub-module needed. The output register and accumulator are each a few lines.

## Test plan
- **Full word:** 32 bits alternating 1,0 (first = 1), `out_ready` = 1 → one word `out_data` = 0x55555555, `out_count` = 32; `in_ready` never drops.
- **Partial flush:** bits 1,1,0,1,0, then `flush` → `out_data` = 0x0000000B, `out_count` = 5, `out_valid` one cycle after the flush edge.
- **Backpressure:** `out_ready` = 0, feed 80 bits of all 1s.
  - First word is held with data 0xFFFFFFFF, count 32.
  - `in_ready` = 0 after 64 bits are accepted.
  - Raise `out_ready` → second word follows with count 32, then the remaining 16 bits are accepted.
- **Empty and same-cycle flush:**
  - Flush with nothing accumulated → `out_valid` stays 0.
  - Flush in the same cycle as a single accepted bit 1 → word 0x00000001, count 1.
- **Reset mid-word:** 10 bits in, assert `rst_n` = 0 asynchronously → all outputs 0 with no clock edge. After release, 32 bits of 0s give count 32 with no residue of the earlier bits.
